// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned DRAIN_CYC_DEFAULT = 4;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDrain  = 2'b01,
    StHalted = 2'b10
  } hz_state_e;

  // Newest producer wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       mem_we, input logic [4:0] mem_rd,
                                         input logic       wb_we,  input logic [4:0] wb_rd);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding selects and WB-to-ID register-file bypass.
module pipeline_hazard_ctrl_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       id_byp_a_o,
  output logic       id_byp_b_o
);

  logic wb_live;

  assign wb_live = wb_reg_write_i && (wb_rd_i != 5'd0);

  assign fwd_a_o = fwd_sel(ex_rs1_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
  assign fwd_b_o = fwd_sel(ex_rs2_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);

  // The register file writes on the edge, so a same-cycle WB value must bypass the read.
  assign id_byp_a_o = wb_live && (wb_rd_i == id_rs1_i);
  assign id_byp_b_o = wb_live && (wb_rd_i == id_rs2_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stall/flush control, halt/drain FSM, performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_sel_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DcW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DcW-1:0] DcLast = DcW'(DRAIN_CYC - 1);

  hz_state_e        state_q, state_d;
  logic [DcW-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic load_use;

  assign mem_stall = icache_stall | dcache_stall;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  pipeline_hazard_ctrl_fwd_unit u_fwd_unit (
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .ex_rs1_i        (ex_rs1),
    .ex_rs2_i        (ex_rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b),
    .id_byp_a_o      (id_byp_a),
    .id_byp_b_o      (id_byp_b)
  );

  always_comb begin
    state_d         = state_q;
    dcnt_d          = dcnt_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    pc_en           = 1'b1;
    ifid_en         = 1'b1;
    idex_en         = 1'b1;
    exmem_en        = 1'b1;
    memwb_en        = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    pc_sel_redirect = 1'b0;
    halted          = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (ex_redirect) begin
          // The ID instruction is wrong-path, so a coincident load-use is moot.
          pc_sel_redirect = 1'b1;
          ifid_flush      = 1'b1;
          idex_flush      = 1'b1;
          flush_cnt_d     = flush_cnt_q + CNT_W'(1);
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_flush  = 1'b1;
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (halt_req) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end
      end

      StDrain: begin
        if (mem_stall) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          if (load_use) begin
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
          if (dcnt_q == DcLast) begin
            state_d = StHalted;
          end else begin
            dcnt_d = dcnt_q + DcW'(1);
          end
        end
      end

      StHalted: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        halted = 1'b1;
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      dcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage RISC-V pipeline. It generates per-stage enable and flush signals from cache stalls, load-use hazards and EX-resolved redirects (taken branch, jal, jalr). It also drives the EX operand forwarding selects and the WB-to-ID register-file bypass. It runs a halt/drain state machine and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of each performance counter
DRAIN_CYC, 4, number of advancing cycles needed to empty the pipeline after a halt request

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
icache_stall  in  1  I-cache miss in progress
dcache_stall  in  1  D-cache miss in progress
id_rs1, id_rs2  in  5  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
ex_rd  in  5  destination register in EX
ex_mem_read  in  1  EX instruction is a load
ex_rs1, ex_rs2  in  5  source registers in EX
mem_rd, wb_rd  in  5  destination registers in MEM / WB
mem_reg_write, wb_reg_write  in  1  MEM / WB instruction writes the register file
ex_redirect  in  1  taken branch, jal or jalr resolved in EX
halt_req  in  1  level request to stop fetch and drain the pipeline
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  pipeline register load enables
ifid_flush, idex_flush  out  1  insert a bubble into IF/ID / ID/EX
pc_sel_redirect  out  1  PC loads the EX target
fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result
id_byp_a, id_byp_b  out  1  ID takes busW instead of the register-file read
halted  out  1  pipeline is empty and frozen
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (asynchronous): state=RUN; drain counter=0; stall_cnt=0; flush_cnt=0; halted=0. Every combinational output follows from state=RUN with all inputs low, so all enables are 1 and all flushes are 0.
- mem_stall = icache_stall | dcache_stall. This has the highest priority.
  - All five enables are 0; both flushes are 0; pc_sel_redirect is 0.
  - Any pending redirect or load-use stall is re-evaluated on the first cycle with mem_stall low, because the EX and ID contents are frozen.
- Load-use hazard: ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_en=0, ifid_en=0, idex_flush=1; downstream stages advance.
  - The stall lasts exactly one cycle per hazard.
- Redirect: ex_redirect with mem_stall low.
  - pc_sel_redirect=1, ifid_flush=1, idex_flush=1.
  - Redirect overrides the load-use hazard (the ID instruction is wrong-path).
- Forwarding for fwd_a (fwd_b is identical using ex_rs2):
  - 01 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1;
  - else 10 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00.
  - MEM has priority over WB.
- WB-to-ID bypass: id_byp_a = wb_reg_write & wb_rd!=0 & wb_rd==id_rs1 (id_byp_b likewise with id_rs2). This is needed because the register file updates on the edge.
- FSM:
  - RUN → DRAIN when halt_req=1. The drain counter clears to 0.
  - DRAIN: pc_en=0, ifid_flush=1. The counter increments only on cycles with mem_stall low. Go to HALTED when the counter equals DRAIN_CYC-1 on an advancing cycle.
  - A redirect during DRAIN is ignored (pc_sel_redirect=0) because fetch is stopped.
  - HALTED: all enables 0; halted=1. Leave only via reset. halt_req deassertion has no effect once DRAIN is entered.
- Counters:
  - stall_cnt increments on each cycle with mem_stall or load-use stall in state RUN.
  - flush_cnt increments on each redirect cycle in RUN.
  - Both wrap modulo 2^CNT_W.
- A reset asserted mid-drain returns the block to RUN immediately and asynchronously.

Decomposition:
- Shared package holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - FSM state encodings RUN, DRAIN, HALTED;
  - the DRAIN_CYC default.
- One natural sub-module: fwd_unit (purely combinational forwarding and bypass compare). The FSM, stall logic and counters stay in the top-level block.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → for one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes 0→1.
- ex_rd=0 with the same other inputs → no stall; all enables 1.
- Double forward: mem_rd=wb_rd=ex_rs1=7, both reg_write=1 → fwd_a=01. With mem_reg_write=0 → fwd_a=10.
- Redirect during dcache_stall held 3 cycles → enables 0 and pc_sel_redirect=0 for those 3 cycles. On the next cycle pc_sel_redirect=1, ifid_flush=1, idex_flush=1, and flush_cnt goes 0→1.
- Redirect together with load-use → pc_en=1, pc_sel_redirect=1, both flushes 1.
- halt_req pulse with icache_stall high for 2 cycles inside the drain → halted rises exactly DRAIN_CYC+2 cycles after DRAIN entry. Then rst_n low mid-HALTED → halted=0 and all enables 1 asynchronously.
